bbox_detect_roi: RTL and testbench
==================================

// Module: bbox_detect_roi
// PURPOSE
//  Single-target bounding-box detector for the binarised video stream. Tracks x/y per pixel and
//  accumulates min/max coordinates and object pixel count over one frame, optionally within a
//  programmable ROI. Commits a frame-stable box plus valid pulse at end of frame for the overlay/tracker.
// PARAMETERS
//  CW       10   coordinate width; x,y saturate at 2**CW-1
//  CNT_W    19   object pixel counter width; saturates at 2**CNT_W-1
//  MIN_PIX  16   minimum object pixels in a frame for rect_flag=1
// PORTS
//  clk              in   1      pixel clock
//  rst_n            in   1      async reset, active-low
//  per_frame_vsync  in   1      high during active frame; rise = frame start, fall = frame end
//  per_frame_href   in   1      high during active line
//  per_frame_clken  in   1      pixel strobe
//  per_img_bit      in   1      1 = object pixel; qualified by href & clken
//  roi_en           in   1      1 = only count pixels inside the ROI
//  roi_x0,roi_x1    in   CW     ROI columns, inclusive
//  roi_y0,roi_y1    in   CW     ROI rows, inclusive
//  rect_valid       out  1      one-cycle pulse when outputs are updated
//  rect_flag        out  1      1 = pix_cnt >= MIN_PIX in the committed frame
//  rect_up,rect_down     out  CW   min/max object row
//  rect_left,rect_right  out  CW   min/max object column
//  pix_cnt          out  CNT_W  object pixels in the committed frame
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; accumulators cleared.
//  Register vsync/href once (vs_d, hs_d). Frame start = vsync & ~vs_d. Frame end = ~vsync & vs_d.
//   Line end = ~href & hs_d.
//  FSM: IDLE -(frame start)-> ACTIVE -(frame end)-> COMMIT -(1 cycle)-> IDLE.
//   IDLE ignores all pixels. Mid-frame after reset: no data is accumulated until the next frame start.
//  Frame start (any state): x=0, y=0, up=left=all-ones, down=right=0, cnt=0. Sample ROI regs into shadow.
//  ACTIVE:
//   - Pixel counts when href & clken & per_img_bit, and (~roi_en_s or x,y inside shadow ROI).
//     A counted pixel updates up/down/left/right with the current x,y. (0,0) is a valid coordinate.
//     cnt increments and saturates.
//   - x increments (saturating) after each href & clken. It clears on line end.
//     y increments (saturating) on line end.
//   - A pixel strobe in the same cycle as line end uses the pre-clear x.
//  COMMIT (the cycle after frame end is detected): load rect_* and pix_cnt from the accumulators.
//   Set rect_flag = (cnt >= MIN_PIX). rect_valid = 1 for exactly this cycle.
//   If cnt < MIN_PIX: rect_up/down/left/right = 0, pix_cnt = cnt.
//  Outputs hold between commits; they never change mid-frame.
//  Frame start while in COMMIT: commit completes, accumulators clear in the same cycle, FSM goes to ACTIVE.
//  Frame end while in IDLE: ignored; no rect_valid.
//  Invalid ROI (x0>x1 or y0>y1) with roi_en=1: no pixels count; rect_flag=0 at commit.
//  Latency: rect_valid is high 2 clk edges after the first edge that samples vsync low.
// STRUCTURE
//  bbox_pkg: CW/CNT_W defaults; state enum {IDLE,ACTIVE,COMMIT}; localparam COORD_MAX.
//  Sub-module sync_edge_det (1-bit register + rise/fall outputs), instantiated for vsync and href.
//  Top: counters, ROI compare, min/max accumulators, FSM, output registers.
// TESTING
//  1. 8x6 frame, single object pixel at (3,2), MIN_PIX=1 -> one rect_valid; up=down=2, left=right=3,
//     pix_cnt=1, flag=1.
//  2. Object block x 2..5, y 1..3, MIN_PIX=16 -> pix_cnt=12, flag=0, box outputs 0.
//     Same with MIN_PIX=12 -> flag=1, box 1/3/2/5.
//  3. Object at (0,0) and (7,5) -> up=0, left=0, down=5, right=7 (corner inclusion).
//  4. roi_en=1, ROI x 4..7, y 0..5, object pixels at x=1 and x=6 -> left=right=6, pix_cnt=1 per row hit.
//     ROI change mid-frame -> no effect until the next frame.
//  5. Assert rst_n mid-frame, release -> no rect_valid for the partial frame.
//     The next full frame commits correct values.
//  6. Back-to-back frames, vsync low for 1 cycle, and clken coincident with the href fall
//     -> two rect_valid pulses, last pixel of each line counted at x=W-1.

Source files
------------

// File: rtl/bbox_detect_roi_pkg.sv
// -----------------------------------------------------------------------------
// bbox_detect_roi_pkg
// Shared constants for the single-target bounding-box detector:
//   - default coordinate / pixel-counter widths and object-size threshold
//   - FSM state encodings (IDLE -> ACTIVE -> COMMIT)
//   - COORD_MAX: saturation value of the x/y counters at the default width
// -----------------------------------------------------------------------------
package bbox_detect_roi_pkg;

    localparam int CW_DEF      = 10;
    localparam int CNT_W_DEF   = 19;
    localparam int MIN_PIX_DEF = 16;

    localparam logic [CW_DEF-1:0] COORD_MAX = {CW_DEF{1'b1}};

    // Frame tracking FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage : bbox_detect_roi_pkg

// File: rtl/bbox_detect_roi_if.sv
// -----------------------------------------------------------------------------
// bbox_detect_roi_if
// Binarised video stream in, committed bounding box out.
//   per_frame_vsync/href/clken, per_img_bit : pixel stream (source -> detector)
//   rect_valid, rect_flag                   : commit pulse and object-present flag
//   rect_up/down/left/right                 : committed box (rows / columns)
//   pix_cnt                                 : committed object pixel count
// modport master : stream source / result consumer
// modport slave  : the detector
// -----------------------------------------------------------------------------
interface bbox_detect_roi_if #(
    parameter int CW    = 10,
    parameter int CNT_W = 19
) ();

    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic             per_img_bit;

    logic             rect_valid;
    logic             rect_flag;
    logic [CW-1:0]    rect_up;
    logic [CW-1:0]    rect_down;
    logic [CW-1:0]    rect_left;
    logic [CW-1:0]    rect_right;
    logic [CNT_W-1:0] pix_cnt;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        input  rect_valid, rect_flag, rect_up, rect_down, rect_left, rect_right, pix_cnt
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        output rect_valid, rect_flag, rect_up, rect_down, rect_left, rect_right, pix_cnt
    );

endinterface : bbox_detect_roi_if

// File: rtl/bbox_detect_roi_sync_edge_det.sv
// -----------------------------------------------------------------------------
// bbox_detect_roi_sync_edge_det
// One-register edge detector for a synchronous level signal.
//   clk, rst_n : clock, async active-low reset
//   d          : level input
//   rise, fall : single-cycle edge indications (combinational from d and d_r)
// The first sample after reset only primes the delay register, so a level that
// is already high when reset releases is not mistaken for a rising edge.
// -----------------------------------------------------------------------------
module bbox_detect_roi_sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_r;
    logic primed_r;

    // Delay register and first-sample priming flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r      <= 1'b0;
            primed_r <= 1'b0;
        end else begin
            d_r      <= d;
            primed_r <= 1'b1;
        end
    end

    assign rise = primed_r &  d & ~d_r;
    assign fall = primed_r & ~d &  d_r;

endmodule : bbox_detect_roi_sync_edge_det

// File: rtl/bbox_detect_roi.sv
// -----------------------------------------------------------------------------
// bbox_detect_roi
// Single-target bounding-box detector for a binarised video stream. Tracks the
// pixel x/y position, accumulates min/max object coordinates and the object
// pixel count over a frame (optionally restricted to an ROI latched at frame
// start) and commits a frame-stable result with a one-cycle rect_valid pulse.
// Ports:
//   clk, rst_n                 : pixel clock, async active-low reset
//   vid (slave)                : stream in / committed box out
//   roi_en                     : restrict counting to the ROI
//   roi_x0/x1, roi_y0/y1       : inclusive ROI columns / rows
// Parameters: CW coordinate width, CNT_W counter width, MIN_PIX object threshold
// -----------------------------------------------------------------------------
module bbox_detect_roi
    import bbox_detect_roi_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    bbox_detect_roi_if.slave vid,
    input  logic             roi_en,
    input  logic [CW-1:0]    roi_x0,
    input  logic [CW-1:0]    roi_x1,
    input  logic [CW-1:0]    roi_y0,
    input  logic [CW-1:0]    roi_y1
);

    localparam logic [CW-1:0]    COORD_ONES = {CW{1'b1}};
    localparam logic [CW-1:0]    COORD_ZERO = {CW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONES   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] MIN_PIX_C  = CNT_W'(MIN_PIX);

    function automatic logic [CW-1:0] coord_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == COORD_ONES) r = v;
        else                 r = v + CW'(1'b1);
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_ONES) r = v;
        else               r = v + CNT_W'(1'b1);
        return r;
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic             frame_start_s, frame_end_s, line_start_s, line_end_s;
    logic             pix_strobe_s, in_roi_s, count_s, flag_s;
    logic [CW-1:0]    px_x_s;
    logic [CW-1:0]    x_r, y_r;
    logic             roi_en_r;
    logic [CW-1:0]    roi_x0_r, roi_x1_r, roi_y0_r, roi_y1_r;
    logic [CW-1:0]    up_r, down_r, left_r, right_r;
    logic [CNT_W-1:0] cnt_r;
    logic             rect_valid_r, rect_flag_r;
    logic [CW-1:0]    rect_up_r, rect_down_r, rect_left_r, rect_right_r;
    logic [CNT_W-1:0] pix_cnt_r;

    bbox_detect_roi_sync_edge_det u_vs_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vid.per_frame_vsync),
        .rise  (frame_start_s),
        .fall  (frame_end_s)
    );

    bbox_detect_roi_sync_edge_det u_hs_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vid.per_frame_href),
        .rise  (line_start_s),
        .fall  (line_end_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // FSM next state; a frame start during COMMIT goes straight back to ACTIVE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) state_nxt_s = ST_ACTIVE;
                else               state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (frame_end_s) state_nxt_s = ST_COMMIT;
                else             state_nxt_s = ST_ACTIVE;
            end
            ST_COMMIT: begin
                if (frame_start_s) state_nxt_s = ST_ACTIVE;
                else               state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pixel qualification. The first strobe of a line always sits at column 0,
    // even if a previous line end was lost; the ROI test uses the frame shadow.
    always_comb begin
        pix_strobe_s = vid.per_frame_href & vid.per_frame_clken;
        if (line_start_s) px_x_s = COORD_ZERO;
        else              px_x_s = x_r;
        in_roi_s = (px_x_s >= roi_x0_r) && (px_x_s <= roi_x1_r) &&
                   (y_r    >= roi_y0_r) && (y_r    <= roi_y1_r);
        if ((state_r == ST_ACTIVE) && !frame_start_s) begin
            count_s = pix_strobe_s & vid.per_img_bit & (~roi_en_r | in_roi_s);
        end else begin
            count_s = 1'b0;
        end
        flag_s = (cnt_r >= MIN_PIX_C);
    end

    // ROI shadow registers, latched at every frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roi_en_r <= 1'b0;
            roi_x0_r <= COORD_ZERO;
            roi_x1_r <= COORD_ZERO;
            roi_y0_r <= COORD_ZERO;
            roi_y1_r <= COORD_ZERO;
        end else if (frame_start_s) begin
            roi_en_r <= roi_en;
            roi_x0_r <= roi_x0;
            roi_x1_r <= roi_x1;
            roi_y0_r <= roi_y0;
            roi_y1_r <= roi_y1;
        end else begin
            roi_en_r <= roi_en_r;
        end
    end

    // Column / row counters; both saturate, column clears at line end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= COORD_ZERO;
            y_r <= COORD_ZERO;
        end else if (frame_start_s) begin
            x_r <= COORD_ZERO;
            y_r <= COORD_ZERO;
        end else if (state_r == ST_ACTIVE) begin
            if (line_end_s) begin
                x_r <= COORD_ZERO;
                y_r <= coord_inc(y_r);
            end else if (pix_strobe_s) begin
                x_r <= coord_inc(px_x_s);
            end else begin
                x_r <= px_x_s;
            end
        end else begin
            x_r <= x_r;
        end
    end

    // Min/max and pixel-count accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_r    <= COORD_ONES;
            left_r  <= COORD_ONES;
            down_r  <= COORD_ZERO;
            right_r <= COORD_ZERO;
            cnt_r   <= CNT_ZERO;
        end else if (frame_start_s) begin
            up_r    <= COORD_ONES;
            left_r  <= COORD_ONES;
            down_r  <= COORD_ZERO;
            right_r <= COORD_ZERO;
            cnt_r   <= CNT_ZERO;
        end else if (count_s) begin
            if (y_r < up_r)       up_r    <= y_r;
            if (y_r > down_r)     down_r  <= y_r;
            if (px_x_s < left_r)  left_r  <= px_x_s;
            if (px_x_s > right_r) right_r <= px_x_s;
            cnt_r <= cnt_inc(cnt_r);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output registers: loaded in COMMIT, held otherwise; small objects report a zero box
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rect_valid_r <= 1'b0;
            rect_flag_r  <= 1'b0;
            rect_up_r    <= COORD_ZERO;
            rect_down_r  <= COORD_ZERO;
            rect_left_r  <= COORD_ZERO;
            rect_right_r <= COORD_ZERO;
            pix_cnt_r    <= CNT_ZERO;
        end else if (state_r == ST_COMMIT) begin
            rect_valid_r <= 1'b1;
            rect_flag_r  <= flag_s;
            pix_cnt_r    <= cnt_r;
            if (flag_s) begin
                rect_up_r    <= up_r;
                rect_down_r  <= down_r;
                rect_left_r  <= left_r;
                rect_right_r <= right_r;
            end else begin
                rect_up_r    <= COORD_ZERO;
                rect_down_r  <= COORD_ZERO;
                rect_left_r  <= COORD_ZERO;
                rect_right_r <= COORD_ZERO;
            end
        end else begin
            rect_valid_r <= 1'b0;
        end
    end

    assign vid.rect_valid = rect_valid_r;
    assign vid.rect_flag  = rect_flag_r;
    assign vid.rect_up    = rect_up_r;
    assign vid.rect_down  = rect_down_r;
    assign vid.rect_left  = rect_left_r;
    assign vid.rect_right = rect_right_r;
    assign vid.pix_cnt    = pix_cnt_r;

endmodule : bbox_detect_roi

// File: tb/tb_bbox_detect_roi.sv
// -----------------------------------------------------------------------------
// tb_bbox_detect_roi
// Two detector instances (MIN_PIX=1 and MIN_PIX=12) see the same stream. Each
// frame image is a 2-D bit array; the expected box is computed from it with
// plain loops and compared against what each instance commits.
// -----------------------------------------------------------------------------
module tb_bbox_detect_roi;

    localparam int CW    = 10;
    localparam int CNT_W = 19;
    localparam int MIN_A = 1;
    localparam int MIN_B = 12;

    typedef struct {
        int cyc;
        int cnt;
        int up;
        int down;
        int left;
        int right;
    } exp_t;

    typedef struct {
        int               cyc;
        logic             flag;
        logic [CW-1:0]    up;
        logic [CW-1:0]    down;
        logic [CW-1:0]    left;
        logic [CW-1:0]    right;
        logic [CNT_W-1:0] cnt;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          roi_en;
    logic [CW-1:0] roi_x0, roi_x1, roi_y0, roi_y1;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            img [0:15][0:15];
    exp_t          exp_q [$];
    snap_t         snap_a [$];
    snap_t         snap_b [$];

    bbox_detect_roi_if #(.CW(CW), .CNT_W(CNT_W)) vif_a ();
    bbox_detect_roi_if #(.CW(CW), .CNT_W(CNT_W)) vif_b ();

    bbox_detect_roi #(.CW(CW), .CNT_W(CNT_W), .MIN_PIX(MIN_A)) u_a (
        .clk(clk), .rst_n(rst_n), .vid(vif_a), .roi_en(roi_en),
        .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1)
    );

    bbox_detect_roi #(.CW(CW), .CNT_W(CNT_W), .MIN_PIX(MIN_B)) u_b (
        .clk(clk), .rst_n(rst_n), .vid(vif_b), .roi_en(roi_en),
        .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every commit pulse of both instances, mid-cycle
    always @(negedge clk) begin
        if (vif_a.rect_valid === 1'b1)
            snap_a.push_back('{cyc, vif_a.rect_flag, vif_a.rect_up, vif_a.rect_down,
                               vif_a.rect_left, vif_a.rect_right, vif_a.pix_cnt});
        if (vif_b.rect_valid === 1'b1)
            snap_b.push_back('{cyc, vif_b.rect_flag, vif_b.rect_up, vif_b.rect_down,
                               vif_b.rect_left, vif_b.rect_right, vif_b.pix_cnt});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vid(input logic vs, input logic hs, input logic ck, input logic b);
        vif_a.per_frame_vsync = vs; vif_a.per_frame_href = hs;
        vif_a.per_frame_clken = ck; vif_a.per_img_bit    = b;
        vif_b.per_frame_vsync = vs; vif_b.per_frame_href = hs;
        vif_b.per_frame_clken = ck; vif_b.per_img_bit    = b;
    endtask

    task automatic clear_img();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = 1'b0;
    endtask

    task automatic rand_img(input int pct);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = ($urandom_range(0, 99) < pct);
    endtask

    // Reference: count set pixels inside the frame (and ROI when enabled)
    function automatic exp_t model(input int w, input int h, input logic ren,
                                   input int x0, input int x1, input int y0, input int y1);
        exp_t e;
        e.cyc = 0; e.cnt = 0; e.up = 1023; e.left = 1023; e.down = 0; e.right = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (img[y][x] && (!ren || (x >= x0 && x <= x1 && y >= y0 && y <= y1))) begin
                    e.cnt++;
                    if (y < e.up)    e.up = y;
                    if (y > e.down)  e.down = y;
                    if (x < e.left)  e.left = x;
                    if (x > e.right) e.right = x;
                end
            end
        end
        return e;
    endfunction

    task automatic send_line(input int yy, input int w, input bit edge_ck);
        int xx;
        bit ck;
        xx = 0;
        while (xx < w) begin
            ck = ($urandom_range(0, 3) != 0);
            if (ck) set_vid(1'b1, 1'b1, 1'b1, img[yy][xx]);
            else    set_vid(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            step();
            if (ck) xx++;
        end
        set_vid(1'b1, 1'b0, edge_ck, edge_ck);
        step();
        set_vid(1'b1, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic send_frame(input int w, input int h, input logic ren,
                              input int x0, input int x1, input int y0, input int y1,
                              input int vlow, input bit edge_ck, input bit scramble);
        exp_t e;
        e = model(w, h, ren, x0, x1, y0, y1);
        roi_en = ren;
        roi_x0 = CW'(x0); roi_x1 = CW'(x1); roi_y0 = CW'(y0); roi_y1 = CW'(y1);
        set_vid(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        for (int yy = 0; yy < h; yy++) begin
            if (scramble && yy == h / 2) begin
                roi_en = 1'($urandom_range(0, 1));
                roi_x0 = CW'($urandom_range(0, 15)); roi_x1 = CW'($urandom_range(0, 15));
                roi_y0 = CW'($urandom_range(0, 15)); roi_y1 = CW'($urandom_range(0, 15));
            end
            send_line(yy, w, edge_ck);
        end
        set_vid(1'b0, 1'b0, 1'b0, 1'b0);
        e.cyc = cyc + 2;
        exp_q.push_back(e);
        repeat (vlow) step();
    endtask

    task automatic check_snap(input string who, input snap_t s, input exp_t e, input int min_pix);
        bit f;
        f = (e.cnt >= min_pix);
        chk({who, "_latency"}, s.cyc, e.cyc);
        chk({who, "_flag"},    s.flag, f);
        chk({who, "_cnt"},     s.cnt, e.cnt);
        chk({who, "_up"},      s.up,    f ? e.up    : 0);
        chk({who, "_down"},    s.down,  f ? e.down  : 0);
        chk({who, "_left"},    s.left,  f ? e.left  : 0);
        chk({who, "_right"},   s.right, f ? e.right : 0);
    endtask

    // Match every expected commit with one pulse from each instance
    task automatic drain();
        exp_t  e;
        snap_t s;
        int    n;
        n = 0;
        repeat (4) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n++;
            chk("valid_seen_a", snap_a.size() > 0, 1);
            if (snap_a.size() > 0) begin s = snap_a.pop_front(); check_snap("a", s, e, MIN_A); end
            chk("valid_seen_b", snap_b.size() > 0, 1);
            if (snap_b.size() > 0) begin s = snap_b.pop_front(); check_snap("b", s, e, MIN_B); end
            if (exp_q.size() == 0) chk("hold_cnt_a", vif_a.pix_cnt, e.cnt);
        end
        chk("extra_valid_a", snap_a.size(), 0);
        chk("extra_valid_b", snap_b.size(), 0);
        if (n == 0) chk("hold_valid_low", vif_a.rect_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        roi_en = 1'b0;
        roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0;
        set_vid(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst_valid", vif_a.rect_valid, 0);
        chk("rst_flag",  vif_a.rect_flag, 0);
        chk("rst_up",    vif_a.rect_up, 0);
        chk("rst_down",  vif_a.rect_down, 0);
        chk("rst_left",  vif_a.rect_left, 0);
        chk("rst_right", vif_a.rect_right, 0);
        chk("rst_cnt",   vif_b.pix_cnt, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // Single pixel at (3,2)
        clear_img(); img[2][3] = 1'b1;
        send_frame(8, 6, 1'b0, 0, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();

        // 4x3 block: exactly at the MIN_B threshold, then one pixel short
        clear_img();
        for (int y = 1; y <= 3; y++) for (int x = 2; x <= 5; x++) img[y][x] = 1'b1;
        send_frame(8, 6, 1'b0, 0, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();
        img[1][2] = 1'b0;
        send_frame(8, 6, 1'b0, 0, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();

        // Corner pixels
        clear_img(); img[0][0] = 1'b1; img[5][7] = 1'b1;
        send_frame(8, 6, 1'b0, 0, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();

        // ROI x 4..7, pixels at x=1 and x=6 on every row; ROI scrambled mid-frame
        clear_img();
        for (int y = 0; y < 6; y++) begin img[y][1] = 1'b1; img[y][6] = 1'b1; end
        send_frame(8, 6, 1'b1, 4, 7, 0, 5, 4, 1'b0, 1'b1);
        drain();

        // Inverted ROI counts nothing
        rand_img(60);
        send_frame(8, 6, 1'b1, 5, 2, 0, 5, 4, 1'b0, 1'b0);
        drain();

        // Reset in mid-frame: the partial frame must not commit
        rand_img(50);
        set_vid(1'b1, 1'b0, 1'b0, 1'b0);
        step(); step();
        send_line(0, 8, 1'b0);
        send_line(1, 8, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_cnt", vif_a.pix_cnt, 0);
        rst_n = 1'b1;
        send_line(2, 8, 1'b0);
        send_line(3, 8, 1'b0);
        set_vid(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step();
        chk("partial_no_valid_a", snap_a.size(), 0);
        chk("partial_no_valid_b", snap_b.size(), 0);
        chk("partial_cnt", vif_a.pix_cnt, 0);
        send_frame(8, 6, 1'b0, 0, 0, 0, 0, 4, 1'b0, 1'b0);
        drain();

        // Back-to-back frames, vsync low one cycle, clken coincident with href fall
        for (int f = 0; f < 3; f++) begin
            rand_img(40);
            for (int y = 0; y < 6; y++) img[y][7] = 1'b1;
            send_frame(8, 6, 1'b0, 0, 0, 0, 0, 1, 1'b1, 1'b0);
        end
        drain();

        // Random frames, sizes, densities and ROIs
        for (int f = 0; f < 8; f++) begin
            rand_img($urandom_range(5, 40));
            send_frame($urandom_range(1, 16), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 8), $urandom_range(4, 15),
                       $urandom_range(0, 6), $urandom_range(3, 11),
                       $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bbox_detect_roi
